// File: rtl/tnoc_axi_burst_splitter.sv
// Splits one NoC request header into legal AXI4 INCR address-channel sub-bursts.
// A sub-burst never exceeds 256 beats and never crosses a 4KB boundary.
module tnoc_axi_burst_splitter #(
    parameter int unsigned ADDRESS_WIDTH     = 64,
    parameter int unsigned DATA_WIDTH        = 256,
    parameter int unsigned BYTE_LENGTH_WIDTH = 13,
    parameter int unsigned ID_WIDTH          = 5
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_req_valid,
    output logic                         o_req_ready,
    input  logic [ID_WIDTH-1:0]          i_req_id,
    input  logic [ADDRESS_WIDTH-1:0]     i_req_address,
    input  logic [2:0]                   i_req_byte_size,
    input  logic [BYTE_LENGTH_WIDTH-1:0] i_req_byte_length,
    output logic                         o_axi_valid,
    input  logic                         i_axi_ready,
    output logic [ID_WIDTH-1:0]          o_axi_id,
    output logic [ADDRESS_WIDTH-1:0]     o_axi_addr,
    output logic [7:0]                   o_axi_len,
    output logic [2:0]                   o_axi_size,
    output logic [1:0]                   o_axi_burst,
    output logic                         o_axi_last_split
);

    localparam int unsigned MAX_SIZE_INT = $clog2(DATA_WIDTH / 8);
    localparam logic [2:0]  MAX_SIZE     = 3'(MAX_SIZE_INT);

    typedef enum logic {StIdle, StIssue} state_t;

    state_t                     state_q, state_d;
    logic [ID_WIDTH-1:0]        id_q, id_d;
    logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]                 len_q, len_d;
    logic [2:0]                 size_q, size_d;
    logic                       last_q, last_d;
    logic [13:0]                remaining_q, remaining_d;

    // Beats that fit before the next 4KB page, capped at 256 and at what is left.
    function automatic logic [8:0] calc_beats(input logic [11:0] offset,
                                              input logic [2:0]  size,
                                              input logic [13:0] remaining);
        logic [12:0] boundary;
        logic [13:0] beats;
        boundary = (13'd4096 - {1'b0, offset}) >> size;
        beats    = remaining;
        if (beats > 14'd256) beats = 14'd256;
        if ({1'b0, boundary} < beats) beats = {1'b0, boundary};
        return beats[8:0];
    endfunction

    logic [2:0]                   req_size;
    logic [6:0]                   req_mask;
    logic [BYTE_LENGTH_WIDTH-1:0] req_length;
    logic [13:0]                  req_total;
    logic [ADDRESS_WIDTH-1:0]     req_aligned;
    logic [8:0]                   req_beats;

    logic [6:0]                   cur_mask;
    logic [ADDRESS_WIDTH-1:0]     cur_aligned;
    logic [8:0]                   cur_beats;
    logic [ADDRESS_WIDTH-1:0]     next_aligned;
    logic [13:0]                  next_remaining;
    logic [8:0]                   next_beats;

    always_comb begin
        req_size    = (i_req_byte_size > MAX_SIZE) ? MAX_SIZE : i_req_byte_size;
        req_mask    = 7'((8'd1 << req_size) - 8'd1);
        // A zero length is illegal; treat it as a single byte.
        req_length  = (i_req_byte_length == '0) ? BYTE_LENGTH_WIDTH'(1) : i_req_byte_length;
        req_total   = (14'(i_req_address[6:0] & req_mask) + 14'(req_length) + 14'(req_mask))
                      >> req_size;
        req_aligned = i_req_address & ~ADDRESS_WIDTH'(req_mask);
        req_beats   = calc_beats(req_aligned[11:0], req_size, req_total);

        cur_mask       = 7'((8'd1 << size_q) - 8'd1);
        cur_aligned    = addr_q & ~ADDRESS_WIDTH'(cur_mask);
        cur_beats      = {1'b0, len_q} + 9'd1;
        next_aligned   = cur_aligned + (ADDRESS_WIDTH'(cur_beats) << size_q);
        next_remaining = remaining_q - 14'(cur_beats);
        next_beats     = calc_beats(next_aligned[11:0], size_q, next_remaining);
    end

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        last_d      = last_q;
        remaining_d = remaining_q;
        unique case (state_q)
            StIdle: begin
                if (i_req_valid) begin
                    state_d     = StIssue;
                    id_d        = i_req_id;
                    addr_d      = i_req_address;
                    size_d      = req_size;
                    remaining_d = req_total;
                    len_d       = 8'(req_beats - 9'd1);
                    last_d      = (14'(req_beats) == req_total);
                end
            end
            StIssue: begin
                if (i_axi_ready) begin
                    if (last_q) begin
                        state_d = StIdle;
                    end else begin
                        addr_d      = next_aligned;
                        remaining_d = next_remaining;
                        len_d       = 8'(next_beats - 9'd1);
                        last_d      = (14'(next_beats) == next_remaining);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            last_q      <= 1'b0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            last_q      <= last_d;
            remaining_q <= remaining_d;
        end
    end

    assign o_req_ready      = (state_q == StIdle);
    assign o_axi_valid      = (state_q == StIssue);
    assign o_axi_id         = id_q;
    assign o_axi_addr       = addr_q;
    assign o_axi_len        = len_q;
    assign o_axi_size       = size_q;
    assign o_axi_burst      = 2'b01;
    assign o_axi_last_split = last_q;

endmodule

// File: tb/tb_tnoc_axi_burst_splitter.sv
// Directed, table-driven bench for tnoc_axi_burst_splitter (default parameters).
module tb_tnoc_axi_burst_splitter;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_id;
    logic [63:0] req_address;
    logic [2:0]  req_byte_size;
    logic [12:0] req_byte_length;
    logic        axi_valid;
    logic        axi_ready;
    logic [4:0]  axi_id;
    logic [63:0] axi_addr;
    logic [7:0]  axi_len;
    logic [2:0]  axi_size;
    logic [1:0]  axi_burst;
    logic        axi_last_split;

    int checks   = 0;
    int failures = 0;

    tnoc_axi_burst_splitter dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_req_valid       (req_valid),
        .o_req_ready       (req_ready),
        .i_req_id          (req_id),
        .i_req_address     (req_address),
        .i_req_byte_size   (req_byte_size),
        .i_req_byte_length (req_byte_length),
        .o_axi_valid       (axi_valid),
        .i_axi_ready       (axi_ready),
        .o_axi_id          (axi_id),
        .o_axi_addr        (axi_addr),
        .o_axi_len         (axi_len),
        .o_axi_size        (axi_size),
        .o_axi_burst       (axi_burst),
        .o_axi_last_split  (axi_last_split)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  id;
        logic [63:0] addr;
        logic [2:0]  bsize;
        logic [12:0] blen;
        logic [2:0]  esize;
        int          n;
        int          stall;
        logic [63:0] ea [3];
        logic [7:0]  el [3];
    } vec_t;

    vec_t tbl [7];

    function automatic vec_t make_vec(input logic [4:0] id, input logic [63:0] addr,
                                      input logic [2:0] bsize, input logic [12:0] blen,
                                      input logic [2:0] esize, input int n, input int stall,
                                      input logic [63:0] a0, input logic [7:0] l0,
                                      input logic [63:0] a1, input logic [7:0] l1,
                                      input logic [63:0] a2, input logic [7:0] l2);
        vec_t v;
        v.id = id; v.addr = addr; v.bsize = bsize; v.blen = blen; v.esize = esize;
        v.n = n; v.stall = stall;
        v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2;
        v.el[0] = l0; v.el[1] = l1; v.el[2] = l2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_burst(input string tag, input vec_t v, input int k);
        chk({tag, " valid"}, 64'(axi_valid), 64'd1);
        chk({tag, " id"},    64'(axi_id), 64'(v.id));
        chk({tag, " addr"},  axi_addr, v.ea[k]);
        chk({tag, " len"},   64'(axi_len), 64'(v.el[k]));
        chk({tag, " size"},  64'(axi_size), 64'(v.esize));
        chk({tag, " burst"}, 64'(axi_burst), 64'd1);
        chk({tag, " last"},  64'(axi_last_split), 64'(k == v.n - 1));
        chk({tag, " ready"}, 64'(req_ready), 64'd0);
    endtask

    task automatic accept(input vec_t v, input string tag);
        @(negedge clk);
        chk({tag, " req_ready idle"}, 64'(req_ready), 64'd1);
        req_valid       = 1'b1;
        req_id          = v.id;
        req_address     = v.addr;
        req_byte_size   = v.bsize;
        req_byte_length = v.blen;
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, " valid latency"}, 64'(axi_valid), 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        accept(v, tag);
        for (int k = 0; k < v.n; k++) begin
            for (int s = 0; s < v.stall; s++) begin
                chk_burst($sformatf("%s sub%0d stall%0d", tag, k, s), v, k);
                @(negedge clk);
            end
            chk_burst($sformatf("%s sub%0d", tag, k), v, k);
            axi_ready = 1'b1;
            @(negedge clk);
            axi_ready = 1'b0;
        end
        chk({tag, " valid drop"}, 64'(axi_valid), 64'd0);
        chk({tag, " ready rise"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        tbl[0] = make_vec(5'd3, 64'h1000, 3'd5, 13'd128, 3'd5, 1, 0,
                          64'h1000, 8'd3, 64'h0, 8'd0, 64'h0, 8'd0);
        tbl[1] = make_vec(5'd7, 64'h1010, 3'd5, 13'd64, 3'd5, 1, 1,
                          64'h1010, 8'd2, 64'h0, 8'd0, 64'h0, 8'd0);
        tbl[2] = make_vec(5'd1, 64'h0FE0, 3'd7, 13'd128, 3'd5, 2, 3,
                          64'h0FE0, 8'd0, 64'h1000, 8'd2, 64'h0, 8'd0);
        tbl[3] = make_vec(5'h1F, 64'h0, 3'd0, 13'd300, 3'd0, 2, 0,
                          64'h0, 8'd255, 64'h100, 8'd43, 64'h0, 8'd0);
        tbl[4] = make_vec(5'd2, 64'h2000, 3'd2, 13'd0, 3'd2, 1, 0,
                          64'h2000, 8'd0, 64'h0, 8'd0, 64'h0, 8'd0);
        tbl[5] = make_vec(5'd4, 64'hFFFF_FFFF_FFFF_FFF0, 3'd4, 13'd32, 3'd4, 2, 0,
                          64'hFFFF_FFFF_FFFF_FFF0, 8'd0, 64'h0, 8'd0, 64'h0, 8'd0);
        tbl[6] = make_vec(5'd9, 64'h10, 3'd3, 13'd4096, 3'd3, 3, 1,
                          64'h10, 8'd255, 64'h810, 8'd253, 64'h1000, 8'd1);

        rst_n = 1'b0; req_valid = 1'b0; axi_ready = 1'b0;
        req_id = '0; req_address = '0; req_byte_size = '0; req_byte_length = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset valid", 64'(axi_valid), 64'd0);
        chk("reset ready", 64'(req_ready), 64'd1);
        chk("reset addr",  axi_addr, 64'd0);
        chk("reset len",   64'(axi_len), 64'd0);
        chk("reset size",  64'(axi_size), 64'd0);
        chk("reset id",    64'(axi_id), 64'd0);
        chk("reset last",  64'(axi_last_split), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Reset after the first handshake of the 256-beat split.
        accept(tbl[3], "rstmid");
        chk_burst("rstmid sub0", tbl[3], 0);
        axi_ready = 1'b1;
        @(negedge clk);
        axi_ready = 1'b0;
        chk_burst("rstmid sub1 shown", tbl[3], 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rstmid valid", 64'(axi_valid), 64'd0);
        chk("rstmid ready", 64'(req_ready), 64'd1);
        chk("rstmid addr",  axi_addr, 64'd0);
        axi_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("rstmid quiet%0d", c), 64'(axi_valid), 64'd0);
        end
        axi_ready = 1'b0;
        run_vec(tbl[0], "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tnoc_axi_burst_splitter.md
Name: tnoc_axi_burst_splitter

Overview:
- Converts one NoC request header into one or more legal AXI4 INCR address-channel requests (AR or AW).
- Sits between the packet-to-AXI header decode stage and the AXI master address channel.
- Clips the burst size to the AXI data width and computes beat counts.
- Splits each request so no sub-burst exceeds 256 beats or crosses a 4KB boundary, and flags the final sub-burst so the response path can merge responses.

Parameters:
- ADDRESS_WIDTH, 64, width of request and AXI address.
- DATA_WIDTH, 256, AXI data width in bits (power of 2, 8..1024). MAX_SIZE = log2(DATA_WIDTH/8).
- BYTE_LENGTH_WIDTH, 13, width of request byte length. Legal range is 1..4096.
- ID_WIDTH, 5, AXI ID width.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  reset
- i_req_valid  input  1  request header valid
- o_req_ready  output  1  request header accepted
- i_req_id  input  ID_WIDTH  AXI ID to issue
- i_req_address  input  ADDRESS_WIDTH  start byte address
- i_req_byte_size  input  3  log2 of element size in bytes
- i_req_byte_length  input  BYTE_LENGTH_WIDTH  total bytes
- o_axi_valid  output  1  AxVALID
- i_axi_ready  input  1  AxREADY
- o_axi_id  output  ID_WIDTH  AxID
- o_axi_addr  output  ADDRESS_WIDTH  AxADDR
- o_axi_len  output  8  AxLEN (beats-1)
- o_axi_size  output  3  AxSIZE
- o_axi_burst  output  2  AxBURST, constant 2'b01 (INCR)
- o_axi_last_split  output  1  this sub-burst completes the request

Behaviour:
- Reset: one clock, synchronous, active-low reset (i_rst_n, sampled on i_clk).
  - State returns to IDLE.
  - o_axi_valid=0, o_req_ready=1 (combinational from IDLE state).
  - o_axi_addr/len/size/id=0, o_axi_last_split=0.
  - Reset mid-split discards all pending sub-bursts; no further AxVALID until a new request is accepted.
- FSM has two states, IDLE and ISSUE.
  - IDLE: o_req_ready=1. On i_req_valid, latch id and compute:
    - size = min(i_req_byte_size, MAX_SIZE)
    - mask = (1<<size)-1
    - total_beats = ((addr & mask) + byte_length + mask) >> size, computed at 14 bits with no overflow.
    - Then go to ISSUE.
  - ISSUE: o_req_ready=0, o_axi_valid=1.
    - First sub-burst presents the original unaligned address.
    - Later sub-bursts present size-aligned addresses.
- Sub-burst sizing:
  - boundary_beats = (4096 - (aligned_addr & 12'hFFF)) >> size
  - beats = min(remaining_beats, 256, boundary_beats)
  - o_axi_len = beats-1
  - o_axi_last_split = (beats == remaining_beats)
- On handshake (o_axi_valid & i_axi_ready):
  - If last: go to IDLE. o_axi_valid drops next cycle and o_req_ready rises next cycle; there is no same-cycle re-accept.
  - Else: aligned_addr += beats<<size, remaining_beats -= beats, stay in ISSUE with o_axi_valid held high. The next sub-burst is presented on the following cycle.
- Latency: request accept cycle N gives first AxVALID in cycle N+1. Each following sub-burst appears 1 cycle after the previous handshake.
- AXI rule: while o_axi_valid=1 and i_axi_ready=0, all o_axi_* outputs stay stable.
- Sub-burst computation is registered. Sub-burst values must not depend combinationally on i_axi_ready.
- A request with i_req_byte_length=0 is illegal. The design treats it as 1 byte.
- Address arithmetic wraps modulo 2^ADDRESS_WIDTH. No error is reported.

Test Plan:
1. Single aligned burst: addr=0x1000, byte_size=5, length=128 (DATA_WIDTH=256) -> one request with addr=0x1000, len=3, size=5, burst=01, last_split=1. AxVALID is seen the cycle after accept.
2. Unaligned start: addr=0x1010, byte_size=5, length=64 -> one request with addr=0x1010, len=2, last_split=1.
3. Size clip plus 4KB crossing: addr=0x0FE0, byte_size=7, length=128 -> size=5. Two requests:
   - addr=0x0FE0, len=0, last=0
   - addr=0x1000, len=2, last=1
4. 256-beat split: addr=0x0, byte_size=0, length=300 -> two requests:
   - addr=0x000, len=255, last=0
   - addr=0x100, len=43, last=1
   - o_req_ready stays 0 until the cycle after the second handshake.
5. Backpressure: during scenario 3, hold i_axi_ready=0 for 3 cycles on each sub-burst -> all outputs stay stable, o_axi_valid stays high, no duplicate or skipped sub-burst.
6. Reset mid-split: during scenario 4, assert i_rst_n=0 after the first handshake -> next cycle o_axi_valid=0 and o_req_ready=1. The second sub-burst is never issued, and a new request then behaves as in scenario 1.
